// File: rtl/mmio_uart_tx_if.sv
// Data-memory bus view of the UART transmit peripheral.
// The CPU side (master) drives store strobe, address and store data.
// The peripheral side (slave) returns the window-select flag and read data.
interface mmio_uart_tx_if;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        sel;
    logic [31:0] rdata;

    modport master (
        output memwrite, dataadr, writedata,
        input  sel, rdata
    );

    modport slave (
        input  memwrite, dataadr, writedata,
        output sel, rdata
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter for the single-cycle MIPS data bus.
// Register window (8 bytes at BASE_ADDR): +0 TXDATA (write pushes a byte),
// +4 STATUS {28'b0, ovf, busy, full, empty} (write bit 3 = 1 clears ovf).
// Bytes are queued in a small FIFO and sent LSB first as 8N1 frames.
// Optional build macro MMIO_UART_TX_PARITY_EN inserts an even-parity bit
// between the last data bit and the stop bit.
// Bus handshake: a store takes effect on the rising clk edge where
// sel & memwrite; loads are served combinationally from registered state.
// state_dbg exposes the FSM state encoding for observation.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FF00,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4,
    parameter int          FIFO_AW      = 2
) (
    input  logic             clk,
    input  logic             reset,
    mmio_uart_tx_if.slave    bus,
    output logic             tx,
    output logic             busy,
    output logic [2:0]       state_dbg
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]      BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0]   CNT_FULL  = (FIFO_AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t             state, state_n;
    logic [BW-1:0]      baud, baud_n;
    logic [2:0]         bit_cnt, bit_n;
    logic [7:0]         data, data_n;
    logic               tx_d;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wptr, rptr;
    logic [FIFO_AW:0]   count;
    logic               ovf;

    logic empty, full, baud_done;
    logic wr, push_req, stat_wr, pop, push_ok, drop;

    // Address decode and register-window access strobes.
    assign bus.sel   = (bus.dataadr[31:3] == BASE_ADDR[31:3]);
    assign wr        = bus.sel & bus.memwrite;
    assign push_req  = wr & ~bus.dataadr[2];
    assign stat_wr   = wr & bus.dataadr[2];

    assign empty     = (count == '0);
    assign full      = (count == CNT_FULL);
    assign baud_done = (baud == BAUD_LAST);

    // A full FIFO still accepts a byte when the FSM pops in the same cycle.
    assign push_ok   = push_req & (~full | pop);
    assign drop      = push_req & full & ~pop;

    assign busy      = (state != IDLE) | ~empty;
    assign state_dbg = state;

    // Loads: TXDATA reads as zero, STATUS returns the flag word.
    assign bus.rdata = (bus.sel && bus.dataadr[2]) ? {28'b0, ovf, busy, full, empty} : 32'b0;

    // Address LSBs and upper store-data bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{bus.dataadr[1:0], bus.writedata[31:8]};

    // FIFO storage, pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wptr] <= bus.writedata[7:0];
                wptr      <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Setting on a drop wins over a same-cycle clear.
            if (drop) begin
                ovf <= 1'b1;
            end else if (stat_wr && bus.writedata[3]) begin
                ovf <= 1'b0;
            end
        end
    end

    // FSM state register plus its counters, byte holder and registered tx.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            data    <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_cnt <= bit_n;
            data    <= data_n;
            tx      <= tx_d;
        end
    end

    // Next-state logic: frame sequencing and baud/bit counting.
    always_comb begin
        state_n = state;
        baud_n  = baud;
        bit_n   = bit_cnt;
        data_n  = data;
        case (state)
            IDLE: begin
                if (pop) begin
                    data_n  = mem[rptr];
                    baud_n  = '0;
                    state_n = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = DATA;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_n = '0;
                    if (bit_cnt == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            PARITY: begin
                if (baud_done) begin
                    baud_n  = '0;
                    state_n = STOP;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_n = '0;
                    if (pop) begin
                        data_n  = mem[rptr];
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                baud_n  = '0;
            end
        endcase
    end

    // Outputs: FIFO pop request and the line level for the coming cycle.
    always_comb begin
        pop  = ~empty & ((state == IDLE) | ((state == STOP) & baud_done));
        tx_d = 1'b1;
        case (state_n)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_n[bit_n];
            PARITY:  tx_d = ^data_n;
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx with CLKS_PER_BIT=4 and a 4-entry FIFO.
// Accepted bytes go into exp_q; a line monitor decodes each frame on tx
// and compares it against the head of the queue.
module tb_mmio_uart_tx;

    localparam int          CPB  = 4;
    localparam logic [31:0] BASE = 32'hFFFF_FF00;
`ifdef MMIO_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk;
    logic       reset;
    logic       tx;
    logic       busy;
    logic [2:0] state_dbg;

    mmio_uart_tx_if u_if();

    mmio_uart_tx #(
        .BASE_ADDR(BASE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(4),
        .FIFO_AW(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(u_if.slave),
        .tx(tx),
        .busy(busy),
        .state_dbg(state_dbg)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    bit         mon_en = 1'b1;

    // Clock and reset.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        reset          = 1'b0;
        u_if.memwrite  = 1'b0;
        u_if.dataadr   = 32'h0;
        u_if.writedata = 32'h0;
    end

    // Watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        u_if.memwrite  = 1'b1;
        u_if.dataadr   = addr;
        u_if.writedata = wdata;
        @(posedge clk);
        #1;
        u_if.memwrite  = 1'b0;
    endtask

    task automatic read_reg(input logic [31:0] addr, output logic [31:0] val);
        u_if.memwrite = 1'b0;
        u_if.dataadr  = addr;
        #1;
        val = u_if.rdata;
    endtask

    task automatic push_byte(input logic [7:0] b);
        exp_q.push_back(b);
        bus_write(BASE, {24'h0, b});
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k;
        k = 0;
        while (busy && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: busy still %b after %0d cycles, need 0", name, busy, budget);
        end
    endtask

    // Line monitor: decodes frames and checks them against exp_q.
    initial begin : line_monitor
        logic [7:0] b;
        logic [7:0] e;
        forever begin
            @(negedge tx);
            if (mon_en && reset) begin
                repeat (CPB/2) @(negedge clk);
                n_cmp++;
                if (tx !== 1'b0) begin
                    n_bad++;
                    $display("FAIL mon_start: tx=%b mid start bit, need 0", tx);
                end
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
`ifdef MMIO_UART_TX_PARITY_EN
                repeat (CPB) @(negedge clk);
                n_cmp++;
                if (tx !== ^b) begin
                    n_bad++;
                    $display("FAIL mon_parity: tx=%b, need %b", tx, ^b);
                end
`endif
                repeat (CPB) @(negedge clk);
                n_cmp++;
                if (tx !== 1'b1) begin
                    n_bad++;
                    $display("FAIL mon_stop: tx=%b mid stop bit, need 1", tx);
                end
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL mon_frame: got byte %02h, expected no frame", b);
                end else begin
                    e = exp_q.pop_front();
                    if (b !== e) begin
                        n_bad++;
                        $display("FAIL mon_frame: got byte %02h, need %02h", b, e);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        logic [31:0] v;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (tx !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_tx: tx=%b, need 1", tx);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_busy: busy=%b, need 0", busy);
        end
        read_reg(BASE + 32'd4, v);
        n_cmp++;
        if (v !== 32'h1) begin
            n_bad++;
            $display("FAIL reset_status: status=%08h, need 00000001", v);
        end
        n_cmp++;
        if (u_if.sel !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_sel: sel=%b for window address, need 1", u_if.sel);
        end
    endtask

    task automatic test_single_frame(input logic [7:0] d);
        logic [10:0] fb;
        logic [31:0] v;
        int bad;
        fb = '1;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[i+1] = d[i];
`ifdef MMIO_UART_TX_PARITY_EN
        fb[9] = ^d;
`endif
        fb[NBITS-1] = 1'b1;
        push_byte(d);
        @(posedge clk);
        #1;
        for (int c = 0; c < NBITS*CPB; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            n_cmp++;
            if (tx !== fb[c/CPB]) begin
                n_bad++;
                $display("FAIL frame_cycle: cycle %0d tx=%b, need %b", c, tx, fb[c/CPB]);
            end
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL frame_end_busy: busy=%b right after frame, need 0", busy);
        end
        read_reg(BASE + 32'd4, v);
        n_cmp++;
        if (v !== 32'h1) begin
            n_bad++;
            $display("FAIL frame_end_status: status=%08h, need 00000001", v);
        end
        bad = 0;
        repeat (2 * CPB) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL frame_idle_line: tx low for %0d idle cycles, need 0", bad);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        logic [7:0]  b;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            if (i < 5) begin
                push_byte(b);
            end else begin
                bus_write(BASE, {24'h0, b});
            end
        end
        read_reg(BASE + 32'd4, v);
        n_cmp++;
        if (v !== 32'hE) begin
            n_bad++;
            $display("FAIL ovf_status: status=%08h, need 0000000E", v);
        end
        bus_write(BASE + 32'd4, 32'h8);
        read_reg(BASE + 32'd4, v);
        n_cmp++;
        if (v !== 32'h6) begin
            n_bad++;
            $display("FAIL ovf_clear: status=%08h, need 00000006", v);
        end
        wait_idle(6 * NBITS * CPB, "ovf_drain");
    endtask

    task automatic test_back_to_back();
        int cnt;
        int k;
        push_byte(8'hA5);
        push_byte(8'h3C);
        k = 0;
        while (tx !== 1'b0 && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        cnt = 0;
        while (busy && cnt < 4 * NBITS * CPB) begin
            cnt++;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (cnt != 2 * NBITS * CPB) begin
            n_bad++;
            $display("FAIL b2b_length: busy for %0d cycles from first start bit, need %0d", cnt, 2 * NBITS * CPB);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] v;
        int bad;
        int k;
        mon_en = 1'b0;
        bus_write(BASE, {24'h0, 8'($urandom_range(0, 255))});
        bus_write(BASE, 32'h0000_00F0);
        k = 0;
        while (tx !== 1'b0 && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        repeat (16) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (tx !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_tx: tx=%b during reset, need 1", tx);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_busy: busy=%b during reset, need 0", busy);
        end
        read_reg(BASE + 32'd4, v);
        n_cmp++;
        if (v !== 32'h1) begin
            n_bad++;
            $display("FAIL rst_mid_status: status=%08h, need 00000001", v);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        bad = 0;
        repeat (3 * NBITS * CPB) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL rst_mid_residual: %0d active cycles after release, need 0", bad);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_parity_frame();
        int cnt;
        int k;
        push_byte(8'h07);
        k = 0;
        while (tx !== 1'b0 && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        cnt = 0;
        while (busy && cnt < 4 * NBITS * CPB) begin
            cnt++;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (cnt != NBITS * CPB) begin
            n_bad++;
            $display("FAIL frame_length: %0d cycles, need %0d", cnt, NBITS * CPB);
        end
    endtask

    task automatic test_decode();
        logic [31:0] v;
        int bad;
        @(negedge clk);
        u_if.memwrite  = 1'b1;
        u_if.dataadr   = 32'hFFFF_FEFC;
        u_if.writedata = 32'h0000_005A;
        #1;
        n_cmp++;
        if (u_if.sel !== 1'b0) begin
            n_bad++;
            $display("FAIL decode_sel: sel=%b, need 0", u_if.sel);
        end
        n_cmp++;
        if (u_if.rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL decode_rdata: rdata=%08h, need 00000000", u_if.rdata);
        end
        @(posedge clk);
        #1;
        u_if.memwrite = 1'b0;
        read_reg(BASE + 32'd4, v);
        n_cmp++;
        if (v !== 32'h1) begin
            n_bad++;
            $display("FAIL decode_status: status=%08h, need 00000001", v);
        end
        read_reg(BASE, v);
        n_cmp++;
        if (v !== 32'h0) begin
            n_bad++;
            $display("FAIL txdata_read: rdata=%08h, need 00000000", v);
        end
        bad = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL decode_no_push: %0d active cycles, need 0", bad);
        end
    endtask

    // Test sequence and final report.
    initial begin : main
        #1;
        test_reset();
        test_single_frame(8'h55);
        test_overflow();
        test_back_to_back();
        wait_idle(4 * NBITS * CPB, "b2b_drain");
        test_reset_mid_frame();
        test_parity_frame();
        wait_idle(2 * NBITS * CPB, "parity_drain");
        test_decode();
        for (int i = 0; i < 4; i++) begin
            test_single_frame(8'($urandom_range(0, 255)));
        end
        repeat (2 * CPB) @(posedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL final_queue: %0d bytes never transmitted, need 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
